// File: rtl/cva6_config_pkg.sv
// Configuration constants, register map and response type shared by the
// configuration info responder and its response FIFO.
package cva6_config_pkg;

    // Core configuration (default build: RV64 with C and A extensions)
    localparam int unsigned CVA6ConfigXlen           = 64;
    localparam bit          CVA6ConfigFpuEn          = 1'b0;
    localparam bit          CVA6ConfigF16En          = 1'b0;
    localparam bit          CVA6ConfigF16AltEn       = 1'b0;
    localparam bit          CVA6ConfigF8En           = 1'b0;
    localparam bit          CVA6ConfigFVecEn         = 1'b0;
    localparam bit          CVA6ConfigCvxifEn        = 1'b0;
    localparam bit          CVA6ConfigCExtEn         = 1'b1;
    localparam bit          CVA6ConfigAExtEn         = 1'b1;
    localparam bit          CVA6ConfigFetchUserEn    = 1'b0;
    localparam bit          CVA6ConfigDataUserEn     = 1'b0;
    localparam bit          CVA6ConfigRenameEn       = 1'b0;
    localparam int unsigned CVA6ConfigFetchUserWidth = CVA6ConfigXlen;
    localparam int unsigned CVA6ConfigDataUserWidth  = CVA6ConfigXlen;

    // Extension bitmap layout
    localparam int unsigned CfgBitsW     = 11;
    localparam int unsigned BitFpu       = 0;
    localparam int unsigned BitF16       = 1;
    localparam int unsigned BitF16Alt    = 2;
    localparam int unsigned BitF8        = 3;
    localparam int unsigned BitFVec      = 4;
    localparam int unsigned BitCvxif     = 5;
    localparam int unsigned BitC         = 6;
    localparam int unsigned BitA         = 7;
    localparam int unsigned BitFetchUser = 8;
    localparam int unsigned BitDataUser  = 9;
    localparam int unsigned BitRename    = 10;

    // Register map byte offsets
    localparam logic [7:0] OffVersion   = 8'h00;
    localparam logic [7:0] OffXlen      = 8'h08;
    localparam logic [7:0] OffCfgBits   = 8'h10;
    localparam logic [7:0] OffFetchUser = 8'h18;
    localparam logic [7:0] OffDataUser  = 8'h20;
    localparam logic [7:0] OffScratch   = 8'h28;

    localparam logic [15:0] CfgVersion = 16'h0001;

    // Response payload is sized for the widest supported XLEN
    localparam int unsigned RspDataW = 64;

    typedef struct packed {
        logic [RspDataW-1:0] data;
        logic                err;
    } cfg_rsp_t;

    // Assemble the extension bitmap from the individual enables
    function automatic logic [CfgBitsW-1:0] cfg_bits_from_enables();
        logic [CfgBitsW-1:0] bits;
        bits               = '0;
        bits[BitFpu]       = CVA6ConfigFpuEn;
        bits[BitF16]       = CVA6ConfigF16En;
        bits[BitF16Alt]    = CVA6ConfigF16AltEn;
        bits[BitF8]        = CVA6ConfigF8En;
        bits[BitFVec]      = CVA6ConfigFVecEn;
        bits[BitCvxif]     = CVA6ConfigCvxifEn;
        bits[BitC]         = CVA6ConfigCExtEn;
        bits[BitA]         = CVA6ConfigAExtEn;
        bits[BitFetchUser] = CVA6ConfigFetchUserEn;
        bits[BitDataUser]  = CVA6ConfigDataUserEn;
        bits[BitRename]    = CVA6ConfigRenameEn;
        return bits;
    endfunction

    localparam logic [CfgBitsW-1:0] CVA6ConfigBits = cfg_bits_from_enables();

endpackage

// File: rtl/cfg_resp_fifo.sv
// Two-entry response FIFO with synchronous active-high reset.
// The caller guarantees push only when space exists (or a pop coincides)
// and pop only when non-empty.
module cfg_resp_fifo
    import cva6_config_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  cfg_rsp_t   data_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output cfg_rsp_t   head_o
);

    cfg_rsp_t   mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    // Pointer and occupancy register with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; entries are only observed through a non-zero count
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; stale entries are unreachable once count is 0.
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Next pointers and count; pointers wrap naturally as 1-bit values
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/config_info_responder.sv
// Read-mostly configuration register block answering a req/gnt bus with
// in-order responses through a 2-deep FIFO, plus one RW scratch register.
module config_info_responder
    import cva6_config_pkg::*;
#(
    parameter int unsigned          XLEN         = CVA6ConfigXlen,
    parameter logic [CfgBitsW-1:0]  CFG_BITS     = CVA6ConfigBits,
    parameter int unsigned          FETCH_USER_W = CVA6ConfigFetchUserWidth,
    parameter int unsigned          DATA_USER_W  = CVA6ConfigDataUserWidth
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [7:0]      addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            gnt_o,
    output logic            rvalid_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            err_o,
    input  logic            rready_i
);

    logic [XLEN-1:0] scratch_q, scratch_d;
    logic            scratch_we;
    cfg_rsp_t        rsp_d;
    cfg_rsp_t        head;
    logic [1:0]      count;
    logic            pop;

    assign pop      = rvalid_o && rready_i;
    assign rvalid_o = (count != 2'd0);
    // A full FIFO can still accept a request when the head leaves this cycle
    assign gnt_o    = req_i && ((count < 2'd2) || ((count == 2'd2) && pop));

    // Decode the request into its response and any scratch update
    always_comb begin
        rsp_d      = '0;
        scratch_we = 1'b0;
        case (addr_i)
            OffVersion:   if (we_i) rsp_d.err = 1'b1; else rsp_d.data = RspDataW'(CfgVersion);
            OffXlen:      if (we_i) rsp_d.err = 1'b1; else rsp_d.data = RspDataW'(XLEN);
            OffCfgBits:   if (we_i) rsp_d.err = 1'b1; else rsp_d.data = RspDataW'(CFG_BITS);
            OffFetchUser: if (we_i) rsp_d.err = 1'b1; else rsp_d.data = RspDataW'(FETCH_USER_W);
            OffDataUser:  if (we_i) rsp_d.err = 1'b1; else rsp_d.data = RspDataW'(DATA_USER_W);
            OffScratch:   if (we_i) scratch_we = 1'b1; else rsp_d.data = RspDataW'(scratch_q);
            default:      rsp_d.err = 1'b1;
        endcase
    end

    // Scratch takes the write data on the granting edge
    always_comb begin
        scratch_d = scratch_q;
        if (gnt_o && scratch_we) begin
            scratch_d = wdata_i;
        end
    end

    // Scratch register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scratch_q <= '0;
        end else begin
            scratch_q <= scratch_d;
        end
    end

    cfg_resp_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt_o && !rst_i),
        .data_i  (rsp_d),
        .pop_i   (pop),
        .count_o (count),
        .head_o  (head)
    );

    // Mask the head so outputs read as zero whenever nothing is pending
    assign rdata_o = rvalid_o ? head.data[XLEN-1:0] : '0;
    assign err_o   = rvalid_o ? head.err : 1'b0;

endmodule

// File: tb/tb_config_info_responder.sv
// Directed bench for config_info_responder: a vector table of single
// transactions followed by hand-written back-to-back, backpressure and
// reset sequences.
module tb_config_info_responder;
    import cva6_config_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [63:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic        err_o;
    logic        rready_i;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [7:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    config_info_responder dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .rready_i (rready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One request with rready held high; response checked one cycle after grant
    task automatic run_single(input vec_t v);
        @(negedge clk_i);
        req_i    = 1'b1;
        we_i     = v.we;
        addr_i   = v.addr;
        wdata_i  = v.wdata;
        rready_i = 1'b1;
        #1 check({v.name, " gnt"}, 64'(gnt_o), 64'd1);
        @(negedge clk_i);
        req_i = 1'b0;
        we_i  = 1'b0;
        #1;
        check({v.name, " rvalid"}, 64'(rvalid_o), 64'd1);
        check({v.name, " rdata"}, rdata_o, v.exp_data);
        check({v.name, " err"}, 64'(err_o), 64'(v.exp_err));
    endtask

    initial begin
        rst_i    = 1'b1;
        req_i    = 1'b0;
        we_i     = 1'b0;
        addr_i   = 8'h00;
        wdata_i  = '0;
        rready_i = 1'b1;

        vecs.push_back('{"rd version",     1'b0, 8'h00, 64'h0, 64'h1,   1'b0});
        vecs.push_back('{"rd xlen",        1'b0, 8'h08, 64'h0, 64'd64,  1'b0});
        vecs.push_back('{"rd cfgbits",     1'b0, 8'h10, 64'h0, 64'h0C0, 1'b0});
        vecs.push_back('{"rd fetchuser",   1'b0, 8'h18, 64'h0, 64'(CVA6ConfigFetchUserWidth), 1'b0});
        vecs.push_back('{"rd datauser",    1'b0, 8'h20, 64'h0, 64'(CVA6ConfigDataUserWidth), 1'b0});
        vecs.push_back('{"rd scratch rst", 1'b0, 8'h28, 64'h0, 64'h0,   1'b0});
        vecs.push_back('{"wr ro 08",       1'b1, 8'h08, 64'h5, 64'h0,   1'b1});
        vecs.push_back('{"rd unaligned0C", 1'b0, 8'h0C, 64'h0, 64'h0,   1'b1});
        vecs.push_back('{"rd above 30",    1'b0, 8'h30, 64'h0, 64'h0,   1'b1});
        vecs.push_back('{"rd scratch kept",1'b0, 8'h28, 64'h0, 64'h0,   1'b0});
        vecs.push_back('{"rd unaligned29", 1'b0, 8'h29, 64'h0, 64'h0,   1'b1});
        vecs.push_back('{"rd FF",          1'b0, 8'hFF, 64'h0, 64'h0,   1'b1});
        vecs.push_back('{"wr scratch",     1'b1, 8'h28, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0});
        vecs.push_back('{"rd scratch",     1'b0, 8'h28, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0});
        vecs.push_back('{"wr ro 10",       1'b1, 8'h10, 64'hFF, 64'h0,  1'b1});
        vecs.push_back('{"rd scratch2",    1'b0, 8'h28, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b0});

        // Reset state
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("reset rvalid", 64'(rvalid_o), 64'd0);
        check("reset rdata", rdata_o, 64'd0);
        check("reset err", 64'(err_o), 64'd0);

        foreach (vecs[i]) run_single(vecs[i]);

        // Back-to-back scratch write then read
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 8'h28; wdata_i = 64'hDEAD_BEEF; rready_i = 1'b1;
        #1 check("b2b wr gnt", 64'(gnt_o), 64'd1);
        @(negedge clk_i);
        we_i = 1'b0; wdata_i = '0;
        #1;
        check("b2b rd gnt", 64'(gnt_o), 64'd1);
        check("b2b wr rvalid", 64'(rvalid_o), 64'd1);
        check("b2b wr rdata", rdata_o, 64'd0);
        check("b2b wr err", 64'(err_o), 64'd0);
        @(negedge clk_i);
        req_i = 1'b0;
        #1;
        check("b2b rd rvalid", 64'(rvalid_o), 64'd1);
        check("b2b rd rdata", rdata_o, 64'hDEAD_BEEF);
        check("b2b rd err", 64'(err_o), 64'd0);
        @(negedge clk_i);
        #1 check("b2b drained", 64'(rvalid_o), 64'd0);

        // Backpressure: two fill the FIFO, third waits until a pop frees space
        rready_i = 1'b0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 8'h00;
        #1 check("bp gnt1", 64'(gnt_o), 64'd1);
        @(negedge clk_i);
        addr_i = 8'h08;
        #1;
        check("bp gnt2", 64'(gnt_o), 64'd1);
        check("bp head1", rdata_o, 64'h1);
        @(negedge clk_i);
        addr_i = 8'h10;
        #1;
        check("bp full nogrant", 64'(gnt_o), 64'd0);
        check("bp hold a", rdata_o, 64'h1);
        @(negedge clk_i);
        #1;
        check("bp still nogrant", 64'(gnt_o), 64'd0);
        check("bp hold b", rdata_o, 64'h1);
        check("bp hold rvalid", 64'(rvalid_o), 64'd1);
        rready_i = 1'b1;
        #1 check("bp pop+gnt", 64'(gnt_o), 64'd1);
        @(negedge clk_i);
        req_i = 1'b0;
        #1 check("bp order2", rdata_o, 64'd64);
        @(negedge clk_i);
        #1 check("bp order3", rdata_o, 64'h0C0);
        @(negedge clk_i);
        #1 check("bp drained", 64'(rvalid_o), 64'd0);

        // Reset with two responses pending
        rready_i = 1'b0;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 8'h00;
        @(negedge clk_i);
        addr_i = 8'h08;
        #1 check("rst pend rvalid", 64'(rvalid_o), 64'd1);
        @(negedge clk_i);
        req_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst rvalid", 64'(rvalid_o), 64'd0);
        check("rst rdata", rdata_o, 64'd0);
        check("rst err", 64'(err_o), 64'd0);
        rready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1 check($sformatf("rst no stale %0d", c), 64'(rvalid_o), 64'd0);
        end
        run_single('{"rst scratch", 1'b0, 8'h28, 64'h0, 64'h0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
